// File: rtl/cdb_result_sender.sv
// CDB transmit endpoint: queues (label, data) results from one functional unit and
// presents the oldest on the bus until granted. Optional macro: CDB_RESULT_SENDER_BYPASS_EN.
module cdb_result_sender #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       inEN,
  input  logic [DATA_W-1:0]          inData,
  input  logic [LABEL_W-1:0]         inLabel,
  output logic                       isFull,
  output logic                       require,
  input  logic                       requireAC,
  output logic [DATA_W-1:0]          dataOut,
  output logic [LABEL_W-1:0]         labelOut,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = LABEL_W + DATA_W;

  localparam logic [PTR_W-1:0]   PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_DEPTH  = CNT_W'(DEPTH);
  localparam logic [LABEL_W-1:0] LABEL_ZERO = {LABEL_W{1'b0}};

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rdPtr_r;
  logic [PTR_W-1:0]   wrPtr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_r;

  logic               headValid_s;
  logic               validIn_s;
  logic               bypassTaken_s;
  logic               popEn_s;
  logic               pushEn_s;
  logic [CNT_W-1:0]   countNext_s;
  logic               require_s;
  logic [DATA_W-1:0]  dataOut_s;
  logic [LABEL_W-1:0] labelOut_s;

  // Handshake decode: label 0 is reserved, a grant only counts while requesting
  always_comb begin
    headValid_s   = (count_r != CNT_ZERO);
    validIn_s     = inEN && (inLabel != LABEL_ZERO);
    popEn_s       = headValid_s && requireAC;
`ifdef CDB_RESULT_SENDER_BYPASS_EN
    // an empty queue granted in the same cycle broadcasts the input directly
    bypassTaken_s = !headValid_s && validIn_s && requireAC;
`else
    bypassTaken_s = 1'b0;
`endif
    pushEn_s      = validIn_s && !bypassTaken_s && (!full_r || popEn_s);
  end

  // Occupancy update for push-only, pop-only, or both
  always_comb begin
    countNext_s = count_r;
    case ({pushEn_s, popEn_s})
      2'b10:   countNext_s = count_r + CNT_ONE;
      2'b01:   countNext_s = count_r - CNT_ONE;
      default: countNext_s = count_r;
    endcase
  end

  // Pointer, count and full-flag state
  always_ff @(posedge clk) begin
    if (RST) begin
      rdPtr_r <= PTR_ZERO;
      wrPtr_r <= PTR_ZERO;
      count_r <= CNT_ZERO;
      full_r  <= 1'b0;
    end else begin
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      if (pushEn_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      count_r <= countNext_s;
      full_r  <= (countNext_s == CNT_DEPTH);
    end
  end

  // Entry storage; contents beyond count are never observed, so no reset needed
  always_ff @(posedge clk) begin
    if (!RST && pushEn_s) begin
      mem_r[wrPtr_r] <= {inLabel, inData};
    end
  end

  // Head presentation; idle cycles drive zeros onto the CDB mux
  always_comb begin
    require_s  = 1'b0;
    dataOut_s  = {DATA_W{1'b0}};
    labelOut_s = LABEL_ZERO;
    if (headValid_s) begin
      require_s               = 1'b1;
      {labelOut_s, dataOut_s} = mem_r[rdPtr_r];
    end
`ifdef CDB_RESULT_SENDER_BYPASS_EN
    else if (validIn_s) begin
      require_s  = 1'b1;
      dataOut_s  = inData;
      labelOut_s = inLabel;
    end
`endif
    else begin
      require_s  = 1'b0;
      dataOut_s  = {DATA_W{1'b0}};
      labelOut_s = LABEL_ZERO;
    end
  end

  assign require  = require_s;
  assign dataOut  = dataOut_s;
  assign labelOut = labelOut_s;
  assign isFull   = full_r;
  assign count    = count_r;

endmodule

// File: tb/tb_cdb_result_sender.sv
// Self-checking bench for cdb_result_sender: directed vector table, latency sequence,
// then randomized traffic against a queue-based reference model.
module tb_cdb_result_sender;

`ifdef CDB_RESULT_SENDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic        inEN;
  logic [31:0] inData;
  logic [3:0]  inLabel;
  logic        isFull;
  logic        require;
  logic        requireAC;
  logic [31:0] dataOut;
  logic [3:0]  labelOut;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  cdb_result_sender #(.DEPTH(4), .DATA_W(32), .LABEL_W(4)) dut (
    .clk(clk), .RST(RST), .inEN(inEN), .inData(inData), .inLabel(inLabel),
    .isFull(isFull), .require(require), .requireAC(requireAC),
    .dataOut(dataOut), .labelOut(labelOut), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] data;
    logic [3:0]  label;
    logic        ac;
    logic        eReq;
    logic [31:0] eData;
    logic [3:0]  eLabel;
    logic [2:0]  eCnt;
    logic        eFull;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addRow(input logic rst, input logic en, input logic [31:0] data,
                        input logic [3:0] label, input logic ac, input logic eReq,
                        input logic [31:0] eData, input logic [3:0] eLabel,
                        input logic [2:0] eCnt, input logic eFull);
    vec_t v;
    v.rst = rst; v.en = en; v.data = data; v.label = label; v.ac = ac;
    v.eReq = eReq; v.eData = eData; v.eLabel = eLabel; v.eCnt = eCnt; v.eFull = eFull;
    tbl.push_back(v);
  endtask

  task automatic idleInputs();
    RST = 1'b0; inEN = 1'b0; inData = 32'h0; inLabel = 4'h0; requireAC = 1'b0;
  endtask

  // reference model: queue of {label, data} in acceptance order
  logic [35:0] q[$];

  function automatic logic modelValid();
    return inEN && (inLabel != 4'h0);
  endfunction

  task automatic modelOutputs(output logic req, output logic [31:0] d, output logic [3:0] l);
    if (q.size() != 0) begin
      req = 1'b1; {l, d} = q[0];
    end else if (BYP && modelValid()) begin
      req = 1'b1; d = inData; l = inLabel;
    end else begin
      req = 1'b0; d = 32'h0; l = 4'h0;
    end
  endtask

  task automatic modelEdge(input logic rst, input logic en, input logic [31:0] d,
                           input logic [3:0] l, input logic ac);
    logic valid, pop, bypTaken, push;
    int   sz;
    valid = en && (l != 4'h0);
    sz    = q.size();
    if (rst) begin
      q.delete();
    end else begin
      pop      = (sz != 0) && ac;
      bypTaken = BYP && (sz == 0) && valid && ac;
      push     = valid && !bypTaken && (sz < 4 || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({l, d});
    end
  endtask

  initial begin
    logic        mReq;
    logic [31:0] mData;
    logic [3:0]  mLabel;
    logic        r, e, a;
    logic [31:0] d;
    logic [3:0]  l;

    // directed vectors; expected values are the state seen after that row's edge
    addRow(1'b0, 1'b1, 32'h0000_0011, 4'h1, 1'b0, 1'b1, 32'h0000_0011, 4'h1, 3'd1, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0012, 4'h2, 1'b0, 1'b1, 32'h0000_0011, 4'h1, 3'd2, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0013, 4'h3, 1'b0, 1'b1, 32'h0000_0011, 4'h1, 3'd3, 1'b0);
    addRow(1'b1, 1'b1, 32'h0000_0014, 4'h4, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 3'd0, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0005, 4'h2, 1'b0, 1'b1, 32'h0000_0005, 4'h2, 3'd1, 1'b0);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'h0000_0005, 4'h2, 3'd1, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0077, 4'h7, 1'b0, 1'b1, 32'h0000_0005, 4'h2, 3'd2, 1'b0);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0077, 4'h7, 3'd1, 1'b0);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 3'd0, 1'b0);
    addRow(1'b0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 3'd0, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0101, 4'h1, 1'b0, 1'b1, 32'h0000_0101, 4'h1, 3'd1, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0102, 4'h2, 1'b0, 1'b1, 32'h0000_0101, 4'h1, 3'd2, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0103, 4'h3, 1'b0, 1'b1, 32'h0000_0101, 4'h1, 3'd3, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0104, 4'h4, 1'b0, 1'b1, 32'h0000_0101, 4'h1, 3'd4, 1'b1);
    addRow(1'b0, 1'b1, 32'h0000_0105, 4'h5, 1'b0, 1'b1, 32'h0000_0101, 4'h1, 3'd4, 1'b1);
    addRow(1'b0, 1'b1, 32'h0000_0106, 4'h6, 1'b1, 1'b1, 32'h0000_0102, 4'h2, 3'd4, 1'b1);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0103, 4'h3, 3'd3, 1'b0);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0104, 4'h4, 3'd2, 1'b0);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0106, 4'h6, 3'd1, 1'b0);
    addRow(1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 3'd0, 1'b0);
    addRow(1'b0, 1'b1, 32'h0000_0999, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 3'd0, 1'b0);

    idleInputs();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    #1;
    chk("reset_require", {63'h0, require}, 64'h0);
    chk("reset_count", {61'h0, count}, 64'h0);
    chk("reset_isFull", {63'h0, isFull}, 64'h0);
    chk("reset_dataOut", {32'h0, dataOut}, 64'h0);
    chk("reset_labelOut", {60'h0, labelOut}, 64'h0);

    foreach (tbl[i]) begin
      RST = tbl[i].rst; inEN = tbl[i].en; inData = tbl[i].data;
      inLabel = tbl[i].label; requireAC = tbl[i].ac;
      @(posedge clk);
      @(negedge clk);
      idleInputs();
      #1;
      chk($sformatf("row%0d_require", i), {63'h0, require}, {63'h0, tbl[i].eReq});
      chk($sformatf("row%0d_dataOut", i), {32'h0, dataOut}, {32'h0, tbl[i].eData});
      chk($sformatf("row%0d_labelOut", i), {60'h0, labelOut}, {60'h0, tbl[i].eLabel});
      chk($sformatf("row%0d_count", i), {61'h0, count}, {61'h0, tbl[i].eCnt});
      chk($sformatf("row%0d_isFull", i), {63'h0, isFull}, {63'h0, tbl[i].eFull});
    end

    // same-cycle latency on an empty queue with an immediate grant
    inEN = 1'b1; inLabel = 4'h3; inData = 32'h0000_0009; requireAC = 1'b1;
    #1;
    chk("lat_require_same", {63'h0, require}, BYP ? 64'h1 : 64'h0);
    chk("lat_dataOut_same", {32'h0, dataOut}, BYP ? 64'h9 : 64'h0);
    chk("lat_labelOut_same", {60'h0, labelOut}, BYP ? 64'h3 : 64'h0);
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    #1;
    chk("lat_count_next", {61'h0, count}, BYP ? 64'h0 : 64'h1);
    chk("lat_require_next", {63'h0, require}, BYP ? 64'h0 : 64'h1);
    requireAC = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    #1;
    chk("lat_drained", {61'h0, count}, 64'h0);

    // randomized traffic against the reference model
    q.delete();
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 1) == 1);
      d = $urandom;
      l = 4'($urandom_range(0, 15));
      RST = r; inEN = e; inData = d; inLabel = l; requireAC = a;
      #1;
      modelOutputs(mReq, mData, mLabel);
      chk("rnd_require", {63'h0, require}, {63'h0, mReq});
      chk("rnd_dataOut", {32'h0, dataOut}, {32'h0, mData});
      chk("rnd_labelOut", {60'h0, labelOut}, {60'h0, mLabel});
      chk("rnd_count", {61'h0, count}, 64'(q.size()));
      chk("rnd_isFull", {63'h0, isFull}, (q.size() == 4) ? 64'h1 : 64'h0);
      @(posedge clk);
      modelEdge(r, e, d, l, a);
      @(negedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
